// File: rtl/writeback_stage_if.sv
// writeback_stage_if: M/W pipeline bus, register-file read ports and retire status
interface writeback_stage_if;
  logic        W_stall;
  logic        W_bubble;
  logic [3:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [3:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic        halted;
  logic [63:0] retired;
  modport master (
    output W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, srcA, srcB,
    input  valA, valB, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, halted, retired
  );
  modport slave (
    input  W_stall, W_bubble, m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM, srcA, srcB,
    output valA, valB, W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM, halted, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: M/W pipeline register, 15-entry register file, halt latch and retire counter
module writeback_stage (
  input logic              clk,
  input logic              rst,
  writeback_stage_if.slave wb
);
  localparam logic [3:0] AOK  = 4'h1;
  localparam logic [3:0] NOP  = 4'h1;
  localparam logic [3:0] NONE = 4'hF;
  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] vale;
    logic [63:0] valm;
  } mw_t;
  localparam mw_t BUBBLE = {AOK, NOP, NONE, NONE, 64'h0, 64'h0};
  mw_t         mw_q, mw_d, m_in;
  logic [63:0] regs_q [15];
  logic [63:0] regs_d [15];
  logic        halted_q, halted_d;
  logic [63:0] retired_q, retired_d;
  logic        we;
  assign m_in = {wb.m_stat, wb.m_icode, wb.m_dstE, wb.m_dstM, wb.m_valE, wb.m_valM};
  assign we   = mw_q.stat == AOK && !halted_q;
  // next M/W contents: stall holds, bubble injects a nop, otherwise take the memory stage
  always_comb mw_d = wb.W_stall ? mw_q : wb.W_bubble ? BUBBLE : m_in;
  // register writes from the current W fields; dstM applied last so it wins a dstE collision
  always_comb begin
    for (int i = 0; i < 15; i++) begin
      regs_d[i] = regs_q[i];
      if (we && mw_q.dste == 4'(i)) regs_d[i] = mw_q.vale;
      if (we && mw_q.dstm == 4'(i)) regs_d[i] = mw_q.valm;
    end
    halted_d  = halted_q || mw_q.stat != AOK;
    retired_d = retired_q + 64'(we && mw_q.icode != NOP && !wb.W_stall);
  end
  // state register; reset loads the bubble and clears the architectural state
  always_ff @(posedge clk) begin
    if (rst) begin
      mw_q      <= BUBBLE;
      regs_q    <= '{default: '0};
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      mw_q      <= mw_d;
      regs_q    <= regs_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end
  // read ports: register contents only, no bypass; index F reads as zero
  always_comb begin
    wb.valA = '0;
    wb.valB = '0;
    for (int i = 0; i < 15; i++) begin
      if (wb.srcA == 4'(i)) wb.valA = regs_q[i];
      if (wb.srcB == 4'(i)) wb.valB = regs_q[i];
    end
  end
  assign wb.W_stat  = mw_q.stat;
  assign wb.W_icode = mw_q.icode;
  assign wb.W_dstE  = mw_q.dste;
  assign wb.W_dstM  = mw_q.dstm;
  assign wb.W_valE  = mw_q.vale;
  assign wb.W_valM  = mw_q.valm;
  assign wb.halted  = halted_q;
  assign wb.retired = retired_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vector table, hand sequence and randomized model comparison
module tb_writeback_stage;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total = 0;
  writeback_stage_if bus ();
  writeback_stage dut (.clk(clk), .rst(rst), .wb(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic rst, stall, bub;
    logic [3:0] stat, icode, dste, dstm;
    logic [63:0] vale, valm;
    logic [3:0] srca, srcb;
    logic [3:0] e_stat, e_icode, e_dste;
    logic [63:0] e_vala, e_valb;
    logic e_halt;
    logic [63:0] e_ret;
  } vec_t;
  vec_t tbl [22];
  logic [3:0]  ms, mi, mde, mdm;
  logic [63:0] mve, mvm, mret;
  logic [63:0] rf [15];
  logic        mh;
  function automatic vec_t v(logic r, logic s, logic b, logic [3:0] st, logic [3:0] ic,
                             logic [3:0] de, logic [3:0] dm, logic [63:0] ve, logic [63:0] vm,
                             logic [3:0] sa, logic [3:0] sb, logic [3:0] es, logic [3:0] ei,
                             logic [3:0] ed, logic [63:0] ea, logic [63:0] eb, logic eh,
                             logic [63:0] er);
    vec_t x;
    x.rst = r; x.stall = s; x.bub = b; x.stat = st; x.icode = ic; x.dste = de; x.dstm = dm;
    x.vale = ve; x.valm = vm; x.srca = sa; x.srcb = sb; x.e_stat = es; x.e_icode = ei;
    x.e_dste = ed; x.e_vala = ea; x.e_valb = eb; x.e_halt = eh; x.e_ret = er;
    return x;
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive(logic r, logic s, logic b, logic [3:0] st, logic [3:0] ic, logic [3:0] de,
                       logic [3:0] dm, logic [63:0] ve, logic [63:0] vm, logic [3:0] sa,
                       logic [3:0] sb);
    rst = r; bus.W_stall = s; bus.W_bubble = b; bus.m_stat = st; bus.m_icode = ic;
    bus.m_dstE = de; bus.m_dstM = dm; bus.m_valE = ve; bus.m_valM = vm; bus.srcA = sa; bus.srcB = sb;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // architectural model: what one clock edge does to the machine, given the inputs now applied
  task automatic model_edge();
    if (rst) begin
      {ms, mi, mde, mdm, mve, mvm} = {4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0};
      foreach (rf[k]) rf[k] = '0;
      mh = 0; mret = 0;
    end else begin
      if (!mh && ms == 1) begin
        if (mde != 4'hF) rf[mde] = mve;
        if (mdm != 4'hF) rf[mdm] = mvm;
        if (mi != 1 && !bus.W_stall) mret = mret + 1;
      end
      if (ms != 1) mh = 1;
      if (!bus.W_stall)
        {ms, mi, mde, mdm, mve, mvm} = bus.W_bubble ? {4'h1, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0}
          : {bus.m_stat, bus.m_icode, bus.m_dstE, bus.m_dstM, bus.m_valE, bus.m_valM};
    end
  endtask
  task automatic compare_model();
    chk("W_stat", bus.W_stat, ms);
    chk("W_icode", bus.W_icode, mi);
    chk("W_dstE", bus.W_dstE, mde);
    chk("W_dstM", bus.W_dstM, mdm);
    chk("W_valE", bus.W_valE, mve);
    chk("W_valM", bus.W_valM, mvm);
    chk("valA", bus.valA, bus.srcA == 4'hF ? 64'h0 : rf[bus.srcA]);
    chk("valB", bus.valB, bus.srcB == 4'hF ? 64'h0 : rf[bus.srcB]);
    chk("halted", 64'(bus.halted), 64'(mh));
    chk("retired", bus.retired, mret);
  endtask
  initial begin
    logic [3:0] F;
    F = 4'hF;
    tbl[0]  = v(1,0,0, 1,1,F,F,0,0, 2,F, 1,1,F,0,0,0,0);
    tbl[1]  = v(0,0,0, 1,3,2,F,'h55,0, 2,F, 1,3,2,0,0,0,0);
    tbl[2]  = v(0,0,0, 1,1,F,F,0,0, 2,F, 1,1,F,'h55,0,0,1);
    tbl[3]  = v(0,0,0, 1,5,4,4,'h100,'h200, 4,2, 1,5,4,0,'h55,0,1);
    tbl[4]  = v(0,0,0, 1,1,F,F,0,0, 4,2, 1,1,F,'h200,'h55,0,2);
    tbl[5]  = v(0,0,0, 1,3,F,F,'hdead,0, F,F, 1,3,F,0,0,0,2);
    tbl[6]  = v(0,0,0, 1,1,F,F,0,0, F,F, 1,1,F,0,0,0,3);
    tbl[7]  = v(0,0,0, 1,3,3,F,'h77,0, 3,F, 1,3,3,0,0,0,3);
    tbl[8]  = v(0,1,0, 1,6,5,F,'h99,0, 3,F, 1,3,3,'h77,0,0,3);
    tbl[9]  = v(0,1,1, 1,6,5,F,'h99,0, 3,F, 1,3,3,'h77,0,0,3);
    tbl[10] = v(0,1,0, 1,6,5,F,'h99,0, 3,F, 1,3,3,'h77,0,0,3);
    tbl[11] = v(0,0,0, 1,1,F,F,0,0, 3,F, 1,1,F,'h77,0,0,4);
    tbl[12] = v(0,0,1, 1,6,5,F,'h99,0, 5,F, 1,1,F,0,0,0,4);
    tbl[13] = v(0,0,0, 1,1,F,F,0,0, 5,F, 1,1,F,0,0,0,4);
    tbl[14] = v(0,0,0, 3,5,F,1,0,'haa, 1,F, 3,5,F,0,0,0,4);
    tbl[15] = v(0,0,0, 1,3,1,F,'h11,0, 1,F, 1,3,1,0,0,1,4);
    tbl[16] = v(0,0,0, 1,1,F,F,0,0, 1,F, 1,1,F,0,0,1,4);
    tbl[17] = v(0,0,0, 1,3,1,F,'h22,0, 1,F, 1,3,1,0,0,1,4);
    tbl[18] = v(1,1,0, 1,3,1,F,'h11,0, 1,2, 1,1,F,0,0,0,0);
    tbl[19] = v(0,0,0, 2,0,F,F,0,0, 2,F, 2,0,F,0,0,0,0);
    tbl[20] = v(0,0,0, 1,1,F,F,0,0, 2,F, 1,1,F,0,0,1,0);
    tbl[21] = v(1,0,0, 1,1,F,F,0,0, 2,F, 1,1,F,0,0,0,0);
    for (int n = 0; n < 22; n++) begin
      drive(tbl[n].rst, tbl[n].stall, tbl[n].bub, tbl[n].stat, tbl[n].icode, tbl[n].dste,
            tbl[n].dstm, tbl[n].vale, tbl[n].valm, tbl[n].srca, tbl[n].srcb);
      tick();
      chk($sformatf("row%0d W_stat", n), bus.W_stat, tbl[n].e_stat);
      chk($sformatf("row%0d W_icode", n), bus.W_icode, tbl[n].e_icode);
      chk($sformatf("row%0d W_dstE", n), bus.W_dstE, tbl[n].e_dste);
      chk($sformatf("row%0d valA", n), bus.valA, tbl[n].e_vala);
      chk($sformatf("row%0d valB", n), bus.valB, tbl[n].e_valb);
      chk($sformatf("row%0d halted", n), 64'(bus.halted), 64'(tbl[n].e_halt));
      chk($sformatf("row%0d retired", n), bus.retired, tbl[n].e_ret);
    end
    // boundary registers 0 and 14 written by one instruction, visible only a cycle later
    drive(0,0,0, 1,6,0,14,'hAAAA,'hBBBB, 0,14);
    tick();
    chk("edge regs pre", bus.valA | bus.valB, 64'h0);
    drive(0,0,0, 1,1,F,F,0,0, 0,14);
    tick();
    chk("edge r0", bus.valA, 64'hAAAA);
    chk("edge r14", bus.valB, 64'hBBBB);
    chk("edge retired", bus.retired, 64'd1);
    drive(0,0,0, 1,3,F,F,'h1234,0, F,F);
    tick();
    chk("srcF zero", bus.valA | bus.valB, 64'h0);
    // randomized run against the architectural model, occasional reset mid-operation
    drive(1,0,0, 1,1,F,F,0,0, F,F);
    model_edge();
    tick();
    compare_model();
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] st;
      r  = $urandom_range(0, 99);
      st = r < 3 ? 4'($urandom_range(2, 4)) : 4'h1;
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
            st, 4'($urandom_range(0, 11)),
            $urandom_range(0, 3) == 0 ? F : 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0 ? 4'($urandom_range(0, 15)) : F,
            {$urandom, $urandom}, {$urandom, $urandom},
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      model_edge();
      tick();
      compare_model();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: all state changes on the rising edge of clk, and rst is sampled only on that edge.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 W_stall  input  1  hold the M/W pipeline register.
REQ-005 W_bubble  input  1  load a bubble into the M/W pipeline register.
REQ-006 m_stat  input  4  memory-stage status (1 AOK, 2 HLT, 3 ADR, 4 INS).
REQ-007 m_icode  input  4  memory-stage instruction code.
REQ-008 m_valE, m_valM  input  64 each  execute result and memory read data.
REQ-009 m_dstE, m_dstM  input  4 each  destination register IDs; 4'hF means none.
REQ-010 srcA, srcB  input  4 each  register-file read addresses.
REQ-011 valA, valB  output  64 each  combinational register-file read data.
REQ-012 W_stat, W_icode, W_dstE, W_dstM  output  4 each  registered M/W fields.
REQ-013 W_valE, W_valM  output  64 each  registered M/W fields.
REQ-014 halted  output  1  sticky indication that a non-AOK status has retired.
REQ-015 retired  output  64  count of retired instructions.

Function
REQ-016 M/W register update priority on each rising edge SHALL be: rst, then W_stall (hold all fields), then W_bubble (load bubble), then load all m_* inputs.
REQ-017 The bubble value SHALL be: stat=1, icode=4'h1 (nop), dstE=dstM=4'hF, valE=valM=0.
REQ-018 The register file SHALL hold 15 x 64-bit registers at indices 0..14; index 4'hF SHALL NOT be storage.
REQ-019 A write is enabled when W_stat==1 and halted==0; writes use the current registered W_* values.
REQ-020 When enabled and W_dstE!=F, R[W_dstE] SHALL take W_valE at the edge.
REQ-021 When enabled and W_dstM!=F, R[W_dstM] SHALL take W_valM at the edge.
REQ-022 When W_dstE==W_dstM!=F, W_valM SHALL win (popq %rsp semantics).
REQ-023 A write SHALL occur while W_stall is high; repeating the same write is permitted.
REQ-024 valA SHALL equal R[srcA], or 0 when srcA==F; valB likewise.
REQ-025 Reads SHALL have no write-through bypass: a write becomes visible on the cycle after its edge. Forwarding belongs to decode.
REQ-026 halted SHALL set at the edge where W_stat!=1 and SHALL clear only on rst.
REQ-027 Once halted==1, all register writes and retired increments SHALL be suppressed, whatever arrives later.
REQ-028 retired SHALL increment by 1 at an edge where W_stat==1, W_icode!=4'h1, halted==0 and W_stall==0. A held instruction is therefore counted once, on its final W cycle.
REQ-029 retired SHALL wrap modulo 2^64.
REQ-030 halt (icode 0) with stat HLT SHALL set halted and SHALL NOT increment retired.

Reset
REQ-031 At an edge with rst=1, the M/W register SHALL take the bubble value of REQ-017.
REQ-032 At the same edge, R[0..14], retired and halted SHALL be cleared to 0.
REQ-033 rst SHALL override W_stall, W_bubble and any pending write in the same cycle, with no partial write.
REQ-034 Asserting rst mid-operation SHALL give the same state as reset from power-up.

Verification
REQ-035 Reset, then m_icode=3, m_stat=1, m_dstE=2, m_valE=0x55 for one cycle: on the next edge R[2]=0x55, srcA=2 reads 0x55 one cycle later, and retired=1.
REQ-036 W_dstE=W_dstM=4, W_valE=0x100, W_valM=0x200, stat AOK: R[4]=0x200.
REQ-037 W_stall=1 for 3 cycles holding an AOK irmovq: W fields unchanged and retired increments once only, after stall release.
REQ-038 W_stall=1 and W_bubble=1 together: hold wins. W_bubble alone: W_icode=1, W_dstE=F, and retired unchanged next cycle.
REQ-039 Retire ADR status, then feed AOK writes to R[1]: halted=1, R[1] unchanged, retired frozen. rst=1 then clears halted, R[1] and retired to 0.
REQ-040 srcA=F and srcB=F: valA=valB=0 regardless of writes to W_dstE=F.
